// File: rtl/p405s_icu_fill_pkg.sv
// rtl/p405s_icu_fill_pkg.sv - shared types and constants for the ICU line-fill sequencer
package p405s_icu_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DATA  = 2'd2,
        TAGWR = 2'd3
    } fill_state_e;

    localparam int   BEATS_LINE = 4;
    localparam logic WAY_A      = 1'b0;
    localparam logic WAY_B      = 1'b1;

endpackage

// File: rtl/p405s_icu_fill_beatctr.sv
// rtl/p405s_icu_fill_beatctr.sv - beat counter, last-beat detect, sticky error and forward-kill flags
module p405s_icu_fill_beatctr #(
    parameter int BEATS = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic beat_i,
    input  logic cacheable_i,
    input  logic rd_err_i,
    input  logic kill_i,
    output logic last_o,
    output logic err_o,
    output logic kill_o
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [1:0] cnt_q;
    logic       err_q;
    logic       kill_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q  <= 2'd0;
            err_q  <= 1'b0;
            kill_q <= 1'b0;
        end else begin
            if (beat_i && (cnt_q != LAST_BEAT)) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (beat_i && rd_err_i) begin
                err_q <= 1'b1;
            end
            if (kill_i) begin
                kill_q <= 1'b1;
            end
        end
    end

    // Flags include the current cycle so a beat sees its own error/abort.
    assign last_o = beat_i && (!cacheable_i || (cnt_q == LAST_BEAT));
    assign err_o  = err_q || (beat_i && rd_err_i);
    assign kill_o = kill_q || kill_i;

endmodule

// File: rtl/p405s_icu_fill_seq.sv
// rtl/p405s_icu_fill_seq.sv - ICU line-fill sequencer: one PLB line read per miss, target beat first
module p405s_icu_fill_seq
    import p405s_icu_fill_pkg::*;
#(
    parameter int BEATS  = BEATS_LINE,
    parameter int ADDR_W = 27,
    parameter int IDX_W  = 8
) (
    input  logic              CB,
    input  logic              reset,
    input  logic              missIn,
    input  logic [ADDR_W-1:0] missAddr,
    input  logic [1:0]        critBeat,
    input  logic              victimWay,
    input  logic              cacheable,
    input  logic              IFB_isAbort2,
    output logic              ICU_plbRequest,
    output logic [ADDR_W-1:0] ICU_plbABus,
    output logic              ICU_plbSize,
    input  logic              PLB_icuAddrAck,
    input  logic              PLB_icuRdDAck,
    input  logic [1:0]        PLB_icuRdWdAddr,
    input  logic [63:0]       PLB_icuRdDBus,
    input  logic              PLB_icuRdErr,
    output logic              arrWrEn,
    output logic              arrWrWay,
    output logic [IDX_W-1:0]  arrWrIdx,
    output logic [1:0]        arrWrBeat,
    output logic [63:0]       arrWrData,
    output logic              tagWrEn,
    output logic              tagWrWay,
    output logic [ADDR_W-1:0] tagWrAddr,
    output logic              tagWrValid,
    output logic              fwdValid,
    output logic [63:0]       fwdData,
    output logic              fillBusy,
    output logic              fillDone,
    output logic              fillErr
);

    fill_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        crit_q;
    logic              way_q;
    logic              cach_q;

    logic              req_q, busy_q;
    logic              arr_en_q;
    logic [1:0]        arr_beat_q;
    logic [63:0]       arr_data_q;
    logic              fwd_q;
    logic [63:0]       fwd_data_q;
    logic              tag_en_q, tag_valid_q;
    logic              done_q, err_q;

    logic start, beat_ok, kill_set, last_beat, err_any, kill_any, fwd_hit;

    assign start    = (state_q == IDLE) && missIn;
    assign beat_ok  = (state_q == DATA) && PLB_icuRdDAck;
    // Abort racing the address ack loses: the fill proceeds, only forwarding dies.
    assign kill_set = ((state_q == REQ) && PLB_icuAddrAck && IFB_isAbort2) ||
                      ((state_q == DATA) && IFB_isAbort2);
    assign fwd_hit  = beat_ok && (PLB_icuRdWdAddr == crit_q) && !kill_any && !PLB_icuRdErr;

    p405s_icu_fill_beatctr #(.BEATS(BEATS)) u_beatctr (
        .clk_i       (CB),
        .reset_i     (reset),
        .clear_i     (start),
        .beat_i      (beat_ok),
        .cacheable_i (cach_q),
        .rd_err_i    (PLB_icuRdErr),
        .kill_i      (kill_set),
        .last_o      (last_beat),
        .err_o       (err_any),
        .kill_o      (kill_any)
    );

    always_ff @(posedge CB) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            crit_q      <= 2'd0;
            way_q       <= WAY_A;
            cach_q      <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            arr_en_q    <= 1'b0;
            arr_beat_q  <= 2'd0;
            arr_data_q  <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            tag_en_q    <= 1'b0;
            tag_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            arr_en_q    <= 1'b0;
            fwd_q       <= 1'b0;
            tag_en_q    <= 1'b0;
            tag_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;

            if (beat_ok) begin
                arr_en_q   <= cach_q;
                arr_beat_q <= PLB_icuRdWdAddr;
                arr_data_q <= PLB_icuRdDBus;
            end
            if (fwd_hit) begin
                fwd_q      <= 1'b1;
                fwd_data_q <= PLB_icuRdDBus;
            end

            case (state_q)
                IDLE: begin
                    if (missIn) begin
                        addr_q  <= missAddr;
                        crit_q  <= critBeat;
                        way_q   <= victimWay;
                        cach_q  <= cacheable;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (PLB_icuAddrAck) begin
                        req_q   <= 1'b0;
                        state_q <= DATA;
                    end else if (IFB_isAbort2) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (last_beat) begin
                        tag_en_q    <= cach_q;
                        tag_valid_q <= cach_q && !err_any;
                        done_q      <= 1'b1;
                        err_q       <= err_any;
                        state_q     <= TAGWR;
                    end
                end
                TAGWR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ICU_plbRequest = req_q;
    assign ICU_plbABus    = addr_q;
    assign ICU_plbSize    = cach_q;
    assign arrWrEn        = arr_en_q;
    assign arrWrWay       = way_q;
    assign arrWrIdx       = addr_q[IDX_W-1:0];
    assign arrWrBeat      = arr_beat_q;
    assign arrWrData      = arr_data_q;
    assign tagWrEn        = tag_en_q;
    assign tagWrWay       = way_q;
    assign tagWrAddr      = addr_q;
    assign tagWrValid     = tag_valid_q;
    assign fwdValid       = fwd_q;
    assign fwdData        = fwd_data_q;
    assign fillBusy       = busy_q;
    assign fillDone       = done_q;
    assign fillErr        = err_q;

endmodule

// File: tb/tb_p405s_icu_fill_seq.sv
// tb/tb_p405s_icu_fill_seq.sv - table-driven self-checking bench for the ICU line-fill sequencer
module tb_p405s_icu_fill_seq;
    import p405s_icu_fill_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        CB, reset;
    logic        missIn, victimWay, cacheable, IFB_isAbort2;
    logic [26:0] missAddr;
    logic [1:0]  critBeat;
    logic        ICU_plbRequest, ICU_plbSize;
    logic [26:0] ICU_plbABus;
    logic        PLB_icuAddrAck, PLB_icuRdDAck, PLB_icuRdErr;
    logic [1:0]  PLB_icuRdWdAddr;
    logic [63:0] PLB_icuRdDBus;
    logic        arrWrEn, arrWrWay;
    logic [7:0]  arrWrIdx;
    logic [1:0]  arrWrBeat;
    logic [63:0] arrWrData;
    logic        tagWrEn, tagWrWay, tagWrValid;
    logic [26:0] tagWrAddr;
    logic        fwdValid, fillBusy, fillDone, fillErr;
    logic [63:0] fwdData;

    p405s_icu_fill_seq dut (
        .CB(CB), .reset(reset), .missIn(missIn), .missAddr(missAddr), .critBeat(critBeat),
        .victimWay(victimWay), .cacheable(cacheable), .IFB_isAbort2(IFB_isAbort2),
        .ICU_plbRequest(ICU_plbRequest), .ICU_plbABus(ICU_plbABus), .ICU_plbSize(ICU_plbSize),
        .PLB_icuAddrAck(PLB_icuAddrAck), .PLB_icuRdDAck(PLB_icuRdDAck),
        .PLB_icuRdWdAddr(PLB_icuRdWdAddr), .PLB_icuRdDBus(PLB_icuRdDBus), .PLB_icuRdErr(PLB_icuRdErr),
        .arrWrEn(arrWrEn), .arrWrWay(arrWrWay), .arrWrIdx(arrWrIdx), .arrWrBeat(arrWrBeat),
        .arrWrData(arrWrData), .tagWrEn(tagWrEn), .tagWrWay(tagWrWay), .tagWrAddr(tagWrAddr),
        .tagWrValid(tagWrValid), .fwdValid(fwdValid), .fwdData(fwdData), .fillBusy(fillBusy),
        .fillDone(fillDone), .fillErr(fillErr)
    );

    // e_out = {request, busy, arrWrEn, fwdValid, tagWrEn, tagWrValid, fillDone, fillErr}
    typedef struct {
        logic        miss;
        logic [26:0] addr;
        logic [1:0]  crit;
        logic        way;
        logic        cach;
        logic        abort;
        logic        aack;
        logic        dack;
        logic [1:0]  wd;
        logic [63:0] data;
        logic        rerr;
        logic [7:0]  e_out;
    } vec_t;

    vec_t        tbl[$];
    logic [26:0] m_addr;
    logic [1:0]  m_crit;
    logic        m_way, m_cach;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cur_row = -1;

    initial begin
        CB = 1'b0;
        forever #5 CB = ~CB;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, cur_row, act, exp_v);
        end
    endtask

    task automatic set_miss(input logic [26:0] a, input logic [1:0] c, input logic w, input logic ca);
        m_addr = a; m_crit = c; m_way = w; m_cach = ca;
    endtask

    task automatic add(input logic miss, input logic abort, input logic aack, input logic dack,
                       input logic [1:0] wd, input logic rerr, input logic [7:0] e_out);
        vec_t v;
        v.miss = miss; v.addr = m_addr; v.crit = m_crit; v.way = m_way; v.cach = m_cach;
        v.abort = abort; v.aack = aack; v.dack = dack; v.wd = wd; v.rerr = rerr;
        v.data = {32'hBEEF0000 + 32'(tbl.size()), 5'h0, m_addr};
        v.e_out = e_out;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        missIn = v.miss; missAddr = v.addr; critBeat = v.crit; victimWay = v.way;
        cacheable = v.cach; IFB_isAbort2 = v.abort; PLB_icuAddrAck = v.aack;
        PLB_icuRdDAck = v.dack; PLB_icuRdWdAddr = v.wd; PLB_icuRdDBus = v.data;
        PLB_icuRdErr = v.rerr;
    endtask

    task automatic idle_inputs();
        missIn = 0; missAddr = '0; critBeat = 0; victimWay = 0; cacheable = 0;
        IFB_isAbort2 = 0; PLB_icuAddrAck = 0; PLB_icuRdDAck = 0; PLB_icuRdWdAddr = 0;
        PLB_icuRdDBus = '0; PLB_icuRdErr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " request"}, 64'(ICU_plbRequest), 0);
        chk({tag, " busy"},    64'(fillBusy), 0);
        chk({tag, " arrWrEn"}, 64'(arrWrEn), 0);
        chk({tag, " fwd"},     64'(fwdValid), 0);
        chk({tag, " tagWrEn"}, 64'(tagWrEn), 0);
        chk({tag, " done"},    64'(fillDone), 0);
        chk({tag, " err"},     64'(fillErr), 0);
        chk({tag, " abus"},    64'(ICU_plbABus), 0);
        chk({tag, " tagaddr"}, 64'(tagWrAddr), 0);
        chk({tag, " arrdata"}, 64'(arrWrData), 0);
    endtask

    logic [26:0] acc_addr;
    logic        acc_way, acc_cach, prev_busy;
    logic [7:0]  e;
    int          cyc;

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge CB);
        #1;
        chk_all_zero("reset");
        @(negedge CB);
        reset = 1'b0;

        // cacheable miss, beats 2,3,0,1 back-to-back
        set_miss(27'h0123456, 2'd2, H, H);
        add(H, L, L, L, 2'd0, L, 8'b1100_0000);
        add(L, L, H, L, 2'd0, L, 8'b0100_0000);
        add(L, L, L, H, 2'd2, L, 8'b0111_0000);
        add(L, L, L, H, 2'd3, L, 8'b0110_0000);
        add(L, L, L, H, 2'd0, L, 8'b0110_0000);
        add(L, L, L, H, 2'd1, L, 8'b0110_1110);
        add(L, L, L, L, 2'd0, L, 8'b0000_0000);
        // abort in REQ, then a stray beat in IDLE
        set_miss(27'h0000ABC, 2'd1, L, H);
        add(H, L, L, L, 2'd0, L, 8'b1100_0000);
        add(L, H, L, L, 2'd0, L, 8'b0000_0000);
        add(L, L, L, H, 2'd1, L, 8'b0000_0000);
        // abort with AddrAck, crit 0; a second miss while busy is ignored
        set_miss(27'h5A5A5A1, 2'd0, L, H);
        add(H, L, L, L, 2'd0, L, 8'b1100_0000);
        add(L, H, H, L, 2'd0, L, 8'b0100_0000);
        set_miss(27'h1111111, 2'd3, H, L);
        add(H, L, L, H, 2'd0, L, 8'b0110_0000);
        add(L, L, L, H, 2'd1, L, 8'b0110_0000);
        add(L, L, L, H, 2'd2, L, 8'b0110_0000);
        add(L, L, L, H, 2'd3, L, 8'b0110_1110);
        add(L, L, L, L, 2'd0, L, 8'b0000_0000);
        // abort in DATA kills forwarding, error on beat 1
        set_miss(27'h0000010, 2'd2, H, H);
        add(H, L, L, L, 2'd0, L, 8'b1100_0000);
        add(L, L, H, L, 2'd0, L, 8'b0100_0000);
        add(L, H, L, L, 2'd0, L, 8'b0100_0000);
        add(L, L, L, H, 2'd1, H, 8'b0110_0000);
        add(L, L, L, H, 2'd2, L, 8'b0110_0000);
        add(L, L, L, H, 2'd3, L, 8'b0110_0000);
        add(L, L, L, H, 2'd0, L, 8'b0110_1011);
        add(L, L, L, L, 2'd0, L, 8'b0000_0000);
        // non-cacheable single beat, done 3 cycles after AddrAck
        set_miss(27'h0000FF3, 2'd1, L, L);
        add(H, L, L, L, 2'd0, L, 8'b1100_0000);
        add(L, L, H, L, 2'd0, L, 8'b0100_0000);
        add(L, L, L, L, 2'd0, L, 8'b0100_0000);
        add(L, L, L, H, 2'd1, L, 8'b0101_0010);
        add(L, L, L, L, 2'd0, L, 8'b0000_0000);

        prev_busy = 1'b0;
        acc_addr = '0; acc_way = 0; acc_cach = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            cur_row = i;
            drive(tbl[i]);
            @(posedge CB);
            #1;
            if (tbl[i].miss && !prev_busy) begin
                acc_addr = tbl[i].addr; acc_way = tbl[i].way; acc_cach = tbl[i].cach;
            end
            e = tbl[i].e_out;
            chk("request",    64'(ICU_plbRequest), 64'(e[7]));
            chk("busy",       64'(fillBusy),       64'(e[6]));
            chk("arrWrEn",    64'(arrWrEn),        64'(e[5]));
            chk("fwdValid",   64'(fwdValid),       64'(e[4]));
            chk("tagWrEn",    64'(tagWrEn),        64'(e[3]));
            chk("tagWrValid", 64'(tagWrValid),     64'(e[2]));
            chk("fillDone",   64'(fillDone),       64'(e[1]));
            chk("fillErr",    64'(fillErr),        64'(e[0]));
            if (e[7]) begin
                chk("abus", 64'(ICU_plbABus), 64'(acc_addr));
                chk("size", 64'(ICU_plbSize), 64'(acc_cach));
            end
            if (e[5]) begin
                chk("arrWrBeat", 64'(arrWrBeat), 64'(tbl[i].wd));
                chk("arrWrWay",  64'(arrWrWay),  64'(acc_way));
                chk("arrWrIdx",  64'(arrWrIdx),  64'(acc_addr[7:0]));
                chk("arrWrData", arrWrData,      tbl[i].data);
            end
            if (e[4]) chk("fwdData", fwdData, tbl[i].data);
            if (e[3]) begin
                chk("tagWrAddr", 64'(tagWrAddr), 64'(acc_addr));
                chk("tagWrWay",  64'(tagWrWay),  64'(acc_way));
            end
            prev_busy = e[6];
            @(negedge CB);
        end

        // reset in DATA after two beats abandons the fill
        cur_row = -1;
        idle_inputs();
        missIn = 1; missAddr = 27'h2222222; critBeat = 0; victimWay = 1; cacheable = 1;
        @(negedge CB);
        missIn = 0; PLB_icuAddrAck = 1;
        @(negedge CB);
        PLB_icuAddrAck = 0; PLB_icuRdDAck = 1; PLB_icuRdWdAddr = 0; PLB_icuRdDBus = 64'h1;
        @(posedge CB);
        #1;
        chk("pre-reset arrWrEn", 64'(arrWrEn), 1);
        @(negedge CB);
        PLB_icuRdWdAddr = 1;
        @(negedge CB);
        reset = 1; PLB_icuRdWdAddr = 2;
        @(posedge CB);
        #1;
        chk_all_zero("midreset");
        @(negedge CB);
        reset = 0; PLB_icuRdWdAddr = 3;
        @(posedge CB);
        #1;
        chk("post-reset arrWrEn", 64'(arrWrEn), 0);
        chk("post-reset busy",    64'(fillBusy), 0);
        chk("post-reset done",    64'(fillDone), 0);
        chk("post-reset tagWrEn", 64'(tagWrEn), 0);
        @(negedge CB);

        // minimum miss-to-done latency with a bounded wait
        idle_inputs();
        missIn = 1; missAddr = 27'h0333333; critBeat = 3; victimWay = 0; cacheable = 1;
        @(posedge CB);
        #1;
        missIn = 0;
        cyc = 1;
        while (cyc < 30 && !fillDone) begin
            PLB_icuAddrAck = (cyc == 1);
            PLB_icuRdDAck  = (cyc >= 2 && cyc <= 5);
            PLB_icuRdWdAddr = 2'(cyc + 1);
            @(posedge CB);
            #1;
            cyc++;
        end
        PLB_icuRdDAck = 0; PLB_icuAddrAck = 0;
        chk("latency fillDone seen", 64'(fillDone), 1);
        chk("latency cycles", 64'(cyc), 64'(2 + BEATS_LINE));
        chk("latency tagWrValid", 64'(tagWrValid), 1);
        @(posedge CB);
        #1;
        chk("busy falls after TAGWR", 64'(fillBusy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/p405s_icu_fill_seq.md
# p405s_icu_fill_seq

Instruction-cache line-fill sequencer, directly downstream of the ICU hit path. It consumes the hit path's miss indication and LRU victim selection. It then runs one PLB line-read per miss, target-beat-first, writes each beat into the selected way of the data array, and forwards the critical beat to the fetch buffer. On completion it writes the tag and valid bit and releases the hit path. While busy, the hit path holds all further lookups.

## Interface
Parameters:
- BEATS, 4, data beats per cacheable line (32-byte line, 64-bit PLB).
- ADDR_W, 27, line address width (effective address bits 0:26).
- IDX_W, 8, cache set index width (low IDX_W bits of the line address).

Ports:
- CB  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- missIn  in  1  lookup missed, sampled only in IDLE.
- missAddr  in  ADDR_W  line address of the miss.
- critBeat  in  2  beat holding the requested word.
- victimWay  in  1  LRU victim: 0 = way A, 1 = way B.
- cacheable  in  1  0 requests a single beat with no array or tag write.
- IFB_isAbort2  in  1  fetch aborted; stop forwarding.
- ICU_plbRequest  out  1  read request.
- ICU_plbABus  out  ADDR_W  request line address.
- ICU_plbSize  out  1  1 = line, 0 = single beat.
- PLB_icuAddrAck  in  1  request accepted.
- PLB_icuRdDAck  in  1  read beat valid.
- PLB_icuRdWdAddr  in  2  beat number of the current data.
- PLB_icuRdDBus  in  64  beat data.
- PLB_icuRdErr  in  1  bus error on the current beat.
- arrWrEn  out  1  data-array beat write.
- arrWrWay  out  1  way written.
- arrWrIdx  out  IDX_W  set index.
- arrWrBeat  out  2  beat slot.
- arrWrData  out  64  beat data.
- tagWrEn  out  1  tag and valid write.
- tagWrWay  out  1  way written.
- tagWrAddr  out  ADDR_W  tag source address.
- tagWrValid  out  1  valid bit written (0 after an error).
- fwdValid  out  1  critical beat to the fetch buffer.
- fwdData  out  64  forwarded data.
- fillBusy  out  1  hit path must hold.
- fillDone  out  1  one-cycle completion pulse.
- fillErr  out  1  one-cycle pulse with fillDone if any beat errored.

## Operation
- States: IDLE, REQ, DATA, TAGWR.
- IDLE:
  - missIn=1 captures missAddr, critBeat, victimWay and cacheable, then moves to REQ.
  - PLB data inputs are ignored.
- REQ:
  - ICU_plbRequest=1, with ABus and Size driven from the captured values.
  - PLB_icuAddrAck moves to DATA.
  - IFB_isAbort2 without AddrAck withdraws the request and returns to IDLE. No fillDone is generated.
  - Abort and AddrAck in the same cycle: the ack wins, the fill continues, and forwarding is suppressed.
- DATA:
  - Each RdDAck increments the beat counter.
  - The last beat (counter = BEATS-1 when cacheable, first beat otherwise) moves to TAGWR.
  - Abort in DATA only sets the fwdKill flag. The line is still filled.
  - RdErr sets a sticky error flag.
- TAGWR (one cycle):
  - cacheable: tagWrEn=1 and tagWrValid=!error.
  - fillDone=1 and fillErr=error.
  - The next state is IDLE.
- The array write is registered from the beat and suppressed when cacheable=0.
- Forwarding: fwdValid=1 for the beat whose WdAddr equals critBeat, if fwdKill=0 and RdErr=0 on that beat.
- The beat counter is 2 bits and saturates at BEATS-1. No wrap is needed; extra acks in TAGWR or IDLE are ignored.

## Timing
- Reset: every output is 0, the state is IDLE, and all flags are cleared. Reset mid-fill abandons the fill. Later PLB beats are ignored in IDLE.
- missIn at cycle t gives ICU_plbRequest=1 and fillBusy=1 from t+1.
- ICU_plbRequest drops the cycle after AddrAck is sampled.
- RdDAck at cycle t gives arrWrEn, arrWrBeat=WdAddr, arrWrData and fwdValid at t+1.
- Last RdDAck at cycle t gives TAGWR at t+1, which is the same cycle as the last arrWrEn. fillDone and tagWrEn are asserted at t+1.
- fillBusy falls at t+2.
- Minimum miss-to-done time is 2 + BEATS cycles with back-to-back acks.
- missIn in any state other than IDLE is ignored.

## Structure
- The shared package p405s_icu_fill_pkg holds:
  - the state enum (IDLE, REQ, DATA, TAGWR);
  - BEATS_LINE=4;
  - way encoding constants WAY_A=0 and WAY_B=1.
- One sub-module, p405s_icu_fill_beatctr, contains the beat counter, the last-beat detect and the sticky error and fwdKill flags.

## Test plan
- Cacheable miss, missAddr=0x0123456, critBeat=2, victimWay=1, acks in order 2,3,0,1 back-to-back -> four arrWrEn with beats 2,3,0,1 to way 1 and index 0x56. fwdValid only on beat 2, one cycle after its ack. tagWrEn with tagWrValid=1 and fillDone in the same cycle as the last array write.
- Abort in REQ before AddrAck -> request drops the next cycle, no array or tag writes, no fillDone, and a new missIn is accepted afterwards.
- Abort coinciding with AddrAck, critBeat=0 -> all 4 beats written, fwdValid never asserted, tag valid written.
- RdErr on beat 1 -> all beats still written, then tagWrValid=0 with fillDone=fillErr=1.
- Non-cacheable miss -> ICU_plbSize=0, one beat, fwdValid=1, arrWrEn=0, tagWrEn=0, and fillDone occurs 3 cycles after the ack.
- Reset asserted in DATA after 2 beats -> outputs 0 on the next cycle. The remaining beats produce no writes.
